// File: rtl/hsi_pkg.sv
// Shared constants for the HSI transmit scheduler: source indices, FSM state codes, CRC defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hsi_pkg;

  // Source slots on the req/src_* vectors
  localparam int SRC_TM  = 0;
  localparam int SRC_BTC = 1;
  localparam int SRC_SR  = 2;
  localparam int SRC_CCW = 3;

  // Scheduler FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_CRC_HI = 3'd3;
  localparam logic [2:0] ST_CRC_LO = 3'd4;
  localparam logic [2:0] ST_END    = 3'd5;

  // CRC16-CCITT, MSB-first, no reflection, no final XOR
  localparam logic [15:0] CRC_INIT_DEF = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_DEF = 16'h1021;

  // Cycles allowed for the coder to raise busy after a strobe
  localparam logic [3:0] BUSY_TO_DEF = 4'd15;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Next-CRC for one byte, MSB-first shift/XOR over 8 bits.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module crc16_ccitt_byte
  import hsi_pkg::*;
#(
  parameter logic [15:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic [15:0] crc,
  input  logic [7:0]  d,
  output logic [15:0] crc_nxt
);

  // Unrolled bitwise LFSR: data bit enters at the top, MSB first
  always_comb begin
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else              c = {c[14:0], 1'b0};
    end
    crc_nxt = c;
  end

endmodule

// File: rtl/hsi_tx_sched.sv
// Fixed-priority frame scheduler: streams the granted source's bytes plus CRC16 to the coder.
// Latency: grant 1 cycle after a masked request; tx_stb 1 cycle after SEND sees vld and !busy.
// Backpressure: holds while cd_busy is high or the source drops vld; busy-rise timeout aborts the frame.
module hsi_tx_sched
  import hsi_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [15:0] CRC_POLY = CRC_POLY_DEF,
  parameter logic [3:0]  BUSY_TO  = BUSY_TO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  req_en,
  input  logic        pre_tm,
  input  logic [3:0]  src_vld,
  input  logic [3:0]  src_last,
  input  logic [31:0] src_d,
  output logic [3:0]  src_ack,
  output logic [3:0]  grant,
  output logic [7:0]  tx_d,
  output logic        tx_stb,
  input  logic        cd_busy,
  output logic [3:0]  frame_end,
  output logic        err
);

  logic [2:0]  state;
  logic [2:0]  ret;
  logic [1:0]  gidx;
  logic [15:0] crc;
  logic [15:0] crc_nxt;
  logic [3:0]  cnt;
  logic [3:0]  m;
  logic [3:0]  gnt_nxt;
  logic [1:0]  idx_nxt;
  logic [7:0]  sel_byte;

  assign sel_byte = src_d[{gidx, 3'b000} +: 8];

  crc16_ccitt_byte #(.CRC_POLY(CRC_POLY)) u_crc (
    .crc     (crc),
    .d       (sel_byte),
    .crc_nxt (crc_nxt)
  );

  // Masked requests and fixed-priority pick (TM highest, CCW lowest, CCW blocked by pre_tm)
  always_comb begin
    m       = req & req_en & {~pre_tm, 3'b111};
    gnt_nxt = 4'b0000;
    idx_nxt = 2'd0;
    if (m[SRC_TM]) begin
      gnt_nxt = 4'b0001;
      idx_nxt = 2'd0;
    end else if (m[SRC_BTC]) begin
      gnt_nxt = 4'b0010;
      idx_nxt = 2'd1;
    end else if (m[SRC_SR]) begin
      gnt_nxt = 4'b0100;
      idx_nxt = 2'd2;
    end else if (m[SRC_CCW]) begin
      gnt_nxt = 4'b1000;
      idx_nxt = 2'd3;
    end
  end

  // Frame FSM; every output is a register, pulses default low each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ret       <= ST_IDLE;
      gidx      <= 2'd0;
      crc       <= CRC_INIT;
      cnt       <= 4'd0;
      grant     <= 4'b0000;
      tx_d      <= 8'h00;
      tx_stb    <= 1'b0;
      src_ack   <= 4'b0000;
      frame_end <= 4'b0000;
      err       <= 1'b0;
    end else begin
      tx_stb    <= 1'b0;
      src_ack   <= 4'b0000;
      frame_end <= 4'b0000;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|m) begin
            grant <= gnt_nxt;
            gidx  <= idx_nxt;
            crc   <= CRC_INIT;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!cd_busy && src_vld[gidx]) begin
            tx_d          <= sel_byte;
            tx_stb        <= 1'b1;
            src_ack[gidx] <= 1'b1;
            crc           <= crc_nxt;
            ret           <= src_last[gidx] ? ST_CRC_HI : ST_SEND;
            cnt           <= 4'd0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The coder must acknowledge each strobe by raising busy
          if (cd_busy) begin
            state <= ret;
          end else if (cnt == BUSY_TO) begin
            err   <= 1'b1;
            grant <= 4'b0000;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_CRC_HI: begin
          if (!cd_busy) begin
            tx_d   <= crc[15:8];
            tx_stb <= 1'b1;
            ret    <= ST_CRC_LO;
            cnt    <= 4'd0;
            state  <= ST_WAIT;
          end
        end
        ST_CRC_LO: begin
          if (!cd_busy) begin
            tx_d   <= crc[7:0];
            tx_stb <= 1'b1;
            ret    <= ST_END;
            cnt    <= 4'd0;
            state  <= ST_WAIT;
          end
        end
        ST_END: begin
          frame_end <= grant;
          grant     <= 4'b0000;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
